// File: rtl/decoder_3to8_if.sv
// rtl/decoder_3to8_if.sv - decode request/result bundle for the column decoder
interface decoder_3to8_if;
    logic       ena;
    logic [2:0] in;
    logic [7:0] out;
    logic       valid;

    modport master (
        output ena,
        output in,
        input  out,
        input  valid
    );

    modport slave (
        input  ena,
        input  in,
        output out,
        output valid
    );
endinterface

// File: rtl/decoder_3to8.sv
// rtl/decoder_3to8.sv - registered 3-to-8 one-hot column decoder with enable
// Optional build macro DECODER_3TO8_HOLD_EN keeps the last column lit while ena is low.
module decoder_3to8 (
    input  logic            clk,
    input  logic            rst_n,
    decoder_3to8_if.slave   bus
);

    logic [7:0] decode;

    always_comb begin
        decode = 8'b1 << bus.in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out   <= 8'h00;
            bus.valid <= 1'b0;
        end else begin
            bus.valid <= bus.ena;
`ifdef DECODER_3TO8_HOLD_EN
            if (bus.ena) begin
                bus.out <= decode;
            end
`else
            // The mux keeps an undriven index from leaking onto out while disabled.
            bus.out <= bus.ena ? decode : 8'h00;
`endif
        end
    end

endmodule

// File: tb/tb_decoder_3to8.sv
// tb/tb_decoder_3to8.sv - scoreboard bench for decoder_3to8
module tb_decoder_3to8;

    logic clk;
    logic rst_n;
    decoder_3to8_if dif ();

    decoder_3to8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] sb [$];
    logic [7:0] model_out;

    // Drive one sample, record its expected result, wait for it to land.
    task automatic cycle(input logic e, input logic [2:0] i);
        @(negedge clk);
        dif.ena = e;
        dif.in  = i;
        if (e) begin
            model_out = 8'h01 << i;
        end else begin
`ifdef DECODER_3TO8_HOLD_EN
            model_out = model_out;
`else
            model_out = 8'h00;
`endif
        end
        sb.push_back({e, model_out});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [8:0] exp;
        rst_n   = 1'b0;
        dif.ena = 1'b0;
        dif.in  = 3'd0;
        model_out = 8'h00;
        #12;
        n_checks++;
        if ({dif.valid, dif.out} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b out=%h, want valid=0 out=00", dif.valid, dif.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 3'd4);
        exp = sb.pop_front();
        n_checks++;
        if ({dif.valid, dif.out} !== exp || dif.out !== 8'h10) begin
            n_fail++;
            $display("FAIL pre_reset_load: got valid=%b out=%h, want valid=1 out=10", dif.valid, dif.out);
        end
        #2;
        rst_n = 1'b0;
        model_out = 8'h00;
        #1;
        n_checks++;
        if ({dif.valid, dif.out} !== 9'h000) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b out=%h, want valid=0 out=00", dif.valid, dif.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep;
        logic [7:0] tbl [8];
        logic [8:0] exp;
        tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, k[2:0]);
            exp = sb.pop_front();
            n_checks++;
            if ({dif.valid, dif.out} !== exp || dif.out !== tbl[k] || dif.valid !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_%0d: got valid=%b out=%h, want valid=1 out=%h", k, dif.valid, dif.out, tbl[k]);
            end
        end
    endtask

    task automatic test_disable;
        logic [8:0] exp;
        logic [7:0] want_off;
`ifdef DECODER_3TO8_HOLD_EN
        want_off = 8'h20;
`else
        want_off = 8'h00;
`endif
        cycle(1'b1, 3'd5);
        exp = sb.pop_front();
        n_checks++;
        if ({dif.valid, dif.out} !== exp || dif.out !== 8'h20) begin
            n_fail++;
            $display("FAIL disable_on: got valid=%b out=%h, want valid=1 out=20", dif.valid, dif.out);
        end
        cycle(1'b0, 3'd3);
        exp = sb.pop_front();
        n_checks++;
        if ({dif.valid, dif.out} !== exp || {dif.valid, dif.out} !== {1'b0, want_off}) begin
            n_fail++;
            $display("FAIL disable_off: got valid=%b out=%h, want valid=0 out=%h", dif.valid, dif.out, want_off);
        end
    endtask

    task automatic test_x_tolerance;
        logic [8:0] exp;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 3'bxxx);
            exp = sb.pop_front();
            n_checks++;
            if ($isunknown({dif.valid, dif.out}) || {dif.valid, dif.out} !== exp) begin
                n_fail++;
                $display("FAIL x_tolerance_%0d: got valid=%b out=%h, want valid=%b out=%h",
                         k, dif.valid, dif.out, exp[8], exp[7:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] exp;
        logic [2:0] seq [6];
        seq = '{3'd7, 3'd0, 3'd6, 3'd1, 3'd3, 3'd3};
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, seq[k]);
            exp = sb.pop_front();
            n_checks++;
            if ({dif.valid, dif.out} !== exp || $countones(dif.out) != 1) begin
                n_fail++;
                $display("FAIL back_to_back_%0d: got valid=%b out=%h, want valid=%b out=%h",
                         k, dif.valid, dif.out, exp[8], exp[7:0]);
            end
        end
    endtask

    task automatic test_random;
        logic [8:0] exp;
        logic       e;
        logic [2:0] i;
        int         bad;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            e = 1'($urandom_range(0, 1));
            i = 3'($urandom_range(0, 7));
            cycle(e, i);
            exp = sb.pop_front();
            n_checks++;
            if ($countones(dif.out) > 1 || {dif.valid, dif.out} !== exp ||
                (dif.valid === 1'b1 && dif.out !== (8'h01 << i))) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_%0d: got valid=%b out=%h, want valid=%b out=%h",
                             k, dif.valid, dif.out, exp[8], exp[7:0]);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sweep();
        test_disable();
        test_x_tolerance();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
